micro_op_sequencer: RTL and testbench

MICRO_OP_SEQUENCER -- requirements
Module: micro_op_sequencer

---
 rtl/micro_op_sequencer.sv | 173 +++++++++++++++++
 tb/tb_micro_op_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_op_sequencer.sv
// Multi-cycle sequencer for one operate (opcode 7) instruction. Group 1 results come from the
// external micro decoder; CLA/OSR/HLT of group 2 are applied here over two extra states.
module micro_op_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] ir,
  input  logic [11:0] ac_in,
  input  logic        l_in,
  input  logic [11:0] pc_in,
  input  logic [11:0] sr,
  input  logic        cont,
  output logic [8:0]  dec_i_reg,
  output logic [11:0] dec_ac,
  output logic        dec_l,
  input  logic [11:0] dec_ac_micro,
  input  logic        dec_l_micro,
  input  logic        dec_skip,
  input  logic        dec_g1,
  input  logic        dec_g2,
  input  logic        dec_g3,
  output logic        busy,
  output logic        done,
  output logic [11:0] ac_out,
  output logic        l_out,
  output logic [11:0] pc_out,
  output logic        halted,
  output logic        op_err,
  output logic        g3_unimpl
);

  typedef enum logic [2:0] {IDLE, DECODE, G2_CLA, G2_OSR, WRITE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [8:0]  ir_reg, ir_next;
  logic [11:0] ac_reg, ac_next;
  logic        l_reg, l_next;
  logic [11:0] pc_reg, pc_next;
  logic [11:0] sr_reg, sr_next;
  logic [11:0] ac_work_reg, ac_work_next;
  logic        l_work_reg, l_work_next;
  logic        skip_reg, skip_next;
  logic        g3u_reg, g3u_next;
  logic [11:0] ac_out_reg, ac_out_next;
  logic        l_out_reg, l_out_next;
  logic [11:0] pc_out_reg, pc_out_next;
  logic        halted_reg, halted_next;
  logic        op_err_reg, op_err_next;

  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    ac_next      = ac_reg;
    l_next       = l_reg;
    pc_next      = pc_reg;
    sr_next      = sr_reg;
    ac_work_next = ac_work_reg;
    l_work_next  = l_work_reg;
    skip_next    = skip_reg;
    g3u_next     = g3u_reg;
    ac_out_next  = ac_out_reg;
    l_out_next   = l_out_reg;
    pc_out_next  = pc_out_reg;
    op_err_next  = 1'b0;
    // cont clears first so a HLT executed in the same cycle overrides it
    halted_next  = halted_reg & ~cont;

    unique case (state_reg)
      IDLE: begin
        if (start && !halted_reg) begin
          if (ir[11:9] == 3'o7) begin
            ir_next    = ir[8:0];
            ac_next    = ac_in;
            l_next     = l_in;
            pc_next    = pc_in;
            sr_next    = sr;
            state_next = DECODE;
          end else begin
            op_err_next = 1'b1;
          end
        end
      end
      DECODE: begin
        if (dec_g1) begin
          ac_work_next = dec_ac_micro;
          l_work_next  = dec_l_micro;
          skip_next    = 1'b0;
          g3u_next     = 1'b0;
          state_next   = WRITE;
        end else if (dec_g2) begin
          // skip is judged on the pre-CLA/OSR accumulator
          ac_work_next = ac_reg;
          l_work_next  = l_reg;
          skip_next    = dec_skip;
          g3u_next     = 1'b0;
          state_next   = G2_CLA;
        end else begin
          ac_work_next = ir_reg[7] ? 12'o0000 : ac_reg;
          l_work_next  = l_reg;
          skip_next    = 1'b0;
          g3u_next     = |ir_reg[6:1];
          state_next   = WRITE;
        end
      end
      G2_CLA: begin
        if (ir_reg[7]) ac_work_next = 12'o0000;
        state_next = G2_OSR;
      end
      G2_OSR: begin
        if (ir_reg[2]) ac_work_next = ac_work_reg | sr_reg;
        if (ir_reg[1]) halted_next = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        ac_out_next = ac_work_reg;
        l_out_next  = l_work_reg;
        pc_out_next = pc_reg + {11'd0, skip_reg};
        state_next  = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ir_reg      <= '0;
      ac_reg      <= '0;
      l_reg       <= 1'b0;
      pc_reg      <= '0;
      sr_reg      <= '0;
      ac_work_reg <= '0;
      l_work_reg  <= 1'b0;
      skip_reg    <= 1'b0;
      g3u_reg     <= 1'b0;
      ac_out_reg  <= '0;
      l_out_reg   <= 1'b0;
      pc_out_reg  <= '0;
      halted_reg  <= 1'b0;
      op_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      ac_reg      <= ac_next;
      l_reg       <= l_next;
      pc_reg      <= pc_next;
      sr_reg      <= sr_next;
      ac_work_reg <= ac_work_next;
      l_work_reg  <= l_work_next;
      skip_reg    <= skip_next;
      g3u_reg     <= g3u_next;
      ac_out_reg  <= ac_out_next;
      l_out_reg   <= l_out_next;
      pc_out_reg  <= pc_out_next;
      halted_reg  <= halted_next;
      op_err_reg  <= op_err_next;
    end
  end

  assign dec_i_reg = ir_reg;
  assign dec_ac    = ac_reg;
  assign dec_l     = l_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign g3_unimpl = done & g3u_reg;
  assign ac_out    = ac_out_reg;
  assign l_out     = l_out_reg;
  assign pc_out    = pc_out_reg;
  assign halted    = halted_reg;
  assign op_err    = op_err_reg;

endmodule

// File: tb/tb_micro_op_sequencer.sv
// Directed bench for micro_op_sequencer: plays the micro decoder, predicts each instruction's
// results from the operate-instruction rules, and checks outputs on every falling edge.
module tb_micro_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, cont;
  logic [11:0] ir, ac_in, pc_in, sr;
  logic        l_in;
  logic [8:0]  dec_i_reg;
  logic [11:0] dec_ac, dec_ac_micro;
  logic        dec_l, dec_l_micro, dec_skip, dec_g1, dec_g2, dec_g3;
  logic        busy, done, l_out, halted, op_err, g3_unimpl;
  logic [11:0] ac_out, pc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  micro_op_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir(ir), .ac_in(ac_in), .l_in(l_in),
    .pc_in(pc_in), .sr(sr), .cont(cont), .dec_i_reg(dec_i_reg), .dec_ac(dec_ac),
    .dec_l(dec_l), .dec_ac_micro(dec_ac_micro), .dec_l_micro(dec_l_micro),
    .dec_skip(dec_skip), .dec_g1(dec_g1), .dec_g2(dec_g2), .dec_g3(dec_g3),
    .busy(busy), .done(done), .ac_out(ac_out), .l_out(l_out), .pc_out(pc_out),
    .halted(halted), .op_err(op_err), .g3_unimpl(g3_unimpl)
  );

  // Group 1 micro-ops used here: CLA, CLL, CMA, CML, IAC (link receives the carry)
  function automatic logic [12:0] g1_ops(input logic [8:0] i, input logic [11:0] a, input logic lv);
    logic [12:0] la;
    la = {lv, a};
    if (i[7]) la[11:0] = 12'o0000;
    if (i[6]) la[12] = 1'b0;
    if (i[5]) la[11:0] = ~la[11:0];
    if (i[4]) la[12] = ~la[12];
    if (i[0]) la = la + 13'd1;
    return la;
  endfunction

  function automatic logic g2_skip(input logic [8:0] i, input logic [11:0] a, input logic lv);
    logic s;
    s = (i[6] & a[11]) | (i[5] & (a == 12'o0000)) | (i[4] & lv);
    return s ^ i[3];
  endfunction

  always_comb begin
    dec_g1 = ~dec_i_reg[8];
    dec_g2 = dec_i_reg[8] & ~dec_i_reg[0];
    dec_g3 = dec_i_reg[8] & dec_i_reg[0];
    {dec_l_micro, dec_ac_micro} = g1_ops(dec_i_reg, dec_ac, dec_l);
    dec_skip = g2_skip(dec_i_reg, dec_ac, dec_l);
  end

  typedef struct {
    logic [11:0] ac;
    logic        l;
    logic [11:0] pc;
    logic        g3u;
    logic        hlt;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [11:0] i, a, input logic lv, input logic [11:0] p, s);
    exp_t e;
    logic [12:0] la;
    e.ac = a; e.l = lv; e.pc = p; e.g3u = 1'b0; e.hlt = 1'b0; e.lat = 3;
    if (!i[8]) begin
      la = g1_ops(i[8:0], a, lv);
      e.ac = la[11:0];
      e.l  = la[12];
    end else if (!i[0]) begin
      e.pc  = p + {11'd0, g2_skip(i[8:0], a, lv)};
      e.ac  = (i[7] ? 12'o0000 : a) | (i[2] ? s : 12'o0000);
      e.hlt = i[1];
      e.lat = 5;
    end else begin
      e.ac  = i[7] ? 12'o0000 : a;
      e.g3u = |i[6:1];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, req);
    end
  endtask

  // committed (held) outputs and the pending result of the instruction in flight
  logic [11:0] exp_ac, exp_pc;
  logic        exp_l;
  exp_t        pend;
  logic        pend_valid;
  logic        model_halted;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_ac", ac_out, 0); check("rst_pc", pc_out, 0); check("rst_l", l_out, 0);
      check("rst_done", done, 0); check("rst_busy", busy, 0); check("rst_halt", halted, 0);
      check("rst_operr", op_err, 0); check("rst_g3", g3_unimpl, 0);
      exp_ac = 0; exp_pc = 0; exp_l = 0; pend_valid = 0; model_halted = 0;
    end else if (done) begin
      check("done_expected", pend_valid, 1);
      check("ac_out", ac_out, pend.ac);
      check("l_out", l_out, pend.l);
      check("pc_out", pc_out, pend.pc);
      check("g3_unimpl", g3_unimpl, pend.g3u);
      exp_ac = pend.ac; exp_l = pend.l; exp_pc = pend.pc;
      pend_valid = 0;
    end else begin
      check("hold_ac", ac_out, exp_ac);
      check("hold_l", l_out, exp_l);
      check("hold_pc", pc_out, exp_pc);
      check("g3_idle", g3_unimpl, 0);
    end
  end

  task automatic run(input logic [11:0] i, a, input logic lv, input logic [11:0] p, s,
                     input bit hold_start);
    int n;
    pend = model(i, a, lv, p, s);
    pend_valid = 1;
    ir = i; ac_in = a; l_in = lv; pc_in = p; sr = s; start = 1'b1;
    @(posedge clk); #2;
    if (!hold_start) start = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) start = 1'b0;
      if (done) begin n = k; break; end
      check("busy_run", busy, 1);
    end
    check("latency", n, pend.lat);
    if (pend.hlt) model_halted = 1;
    @(posedge clk); #2;
    check("busy_after", busy, 0);
    check("halted", halted, model_halted);
    $display("txn ir=%04o ac=%04o l=%0d pc=%04o sr=%04o -> ac=%04o l=%0d pc=%04o g3u=%0d halt=%0d lat=%0d",
             i, a, lv, p, s, ac_out, l_out, pc_out, pend.g3u, halted, n);
  endtask

  initial begin
    reset_n = 0; start = 0; cont = 0; ir = 0; ac_in = 0; l_in = 0; pc_in = 0; sr = 0;
    pend_valid = 0; model_halted = 0; exp_ac = 0; exp_pc = 0; exp_l = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(posedge clk); #2;

    // group 1 CLA CLL
    run(12'o7300, 12'o1234, 1'b1, 12'o0200, 12'o0000, 0);
    check("lit_7300_ac", ac_out, 12'o0000); check("lit_7300_l", l_out, 0);
    check("lit_7300_pc", pc_out, 12'o0200);
    run(12'o7001, 12'o7777, 1'b0, 12'o0010, 12'o0000, 0);
    check("lit_iac_l", l_out, 1);
    run(12'o7040, 12'o1234, 1'b0, 12'o0011, 12'o0000, 0);
    check("lit_cma_ac", ac_out, 12'o6543);
    // group 2 SMA skip with PC wrap
    run(12'o7500, 12'o4000, 1'b0, 12'o7777, 12'o0000, 0);
    check("lit_7500_pc", pc_out, 12'o0000); check("lit_7500_ac", ac_out, 12'o4000);
    run(12'o7604, 12'o5555, 1'b0, 12'o0300, 12'o0707, 0);
    check("lit_7604_ac", ac_out, 12'o0707); check("lit_7604_pc", pc_out, 12'o0300);
    run(12'o7440, 12'o0000, 1'b0, 12'o0400, 12'o0000, 0);
    run(12'o7440, 12'o0001, 1'b0, 12'o0400, 12'o0000, 0);
    run(12'o7510, 12'o0100, 1'b1, 12'o0500, 12'o0000, 1);
    check("lit_spa_pc", pc_out, 12'o0501);
    // group 3 with unimplemented bits
    run(12'o7621, 12'o3333, 1'b1, 12'o0600, 12'o0000, 0);
    check("lit_7621_ac", ac_out, 12'o0000);

    // illegal opcode
    ir = 12'o1234; start = 1; @(posedge clk); #2 start = 0;
    @(negedge clk); check("op_err_pulse", op_err, 1); check("op_err_busy", busy, 0);
    @(negedge clk); check("op_err_clear", op_err, 0); check("op_err_busy2", busy, 0);
    $display("txn ir=1234 -> op_err pulse");

    // halt, ignored start, continue
    run(12'o7402, 12'o0017, 1'b0, 12'o0700, 12'o0000, 0);
    check("lit_hlt", halted, 1);
    ir = 12'o7300; start = 1; @(posedge clk); #2 start = 0;
    @(negedge clk); check("halt_busy", busy, 0); check("halt_noerr", op_err, 0);
    @(negedge clk); check("halt_busy2", busy, 0);
    ir = 12'o1234; start = 1; @(posedge clk); #2 start = 0;
    @(negedge clk); check("halt_noerr2", op_err, 0);
    cont = 1; @(posedge clk); #2 cont = 0; model_halted = 0;
    check("cont_clear", halted, 0);
    $display("txn cont -> halted=%0d", halted);
    run(12'o7300, 12'o0055, 1'b1, 12'o1000, 12'o0000, 0);

    // reset mid-instruction
    run(12'o7040, 12'o0000, 1'b0, 12'o1100, 12'o0000, 0);
    pend = model(12'o7300, 12'o1234, 1'b1, 12'o0200, 12'o0000);
    pend_valid = 1;
    ir = 12'o7300; ac_in = 12'o1234; l_in = 1; pc_in = 12'o0200; start = 1;
    @(posedge clk); #2 start = 0;
    @(posedge clk); #2 reset_n = 0;
    #1;
    check("async_busy", busy, 0); check("async_ac", ac_out, 0);
    check("async_pc", pc_out, 0); check("async_done", done, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    $display("txn reset mid 7300 -> ac=%04o pc=%04o busy=%0d", ac_out, pc_out, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
